alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of the operation counter in REQ-028.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 The block SHALL have port reqValid  input  1  request present.
REQ-005 The block SHALL have port reqReady  output  1  request accepted when high together with reqValid.
REQ-006 The block SHALL have port reqOpcode  input  11  LEGv8 opcode field, instruction bits [31:21].
REQ-007 The block SHALL have ports reqData1 and reqData2, each input  32  operands.
REQ-008 The block SHALL have port aluControl  output  4  control code to the ALU.
REQ-009 The block SHALL have ports data1 and data2, each output  32  ALU operands.
REQ-010 The block SHALL have ports aluResult  input  32, overflow  input  1 and zeroFlag  input  1, carrying combinational ALU outputs.
REQ-011 The block SHALL have ports respValid  output  1 and respReady  input  1, forming the response handshake.
REQ-012 The block SHALL have ports respResult  output  32, respOverflow  output  1, respZero  output  1 and respIllegal  output  1.

Function
REQ-013 The state machine SHALL have states IDLE, ISSUE and RESP.
REQ-014 reqReady SHALL be 1 only in IDLE; a request is accepted on an edge where the FSM is in IDLE and reqValid=1.
REQ-015 On accept, the block SHALL register aluControl, data1=reqData1 and data2=reqData2, and SHALL go to ISSUE for legal opcodes or to RESP for illegal opcodes.
REQ-016 Decode SHALL be: ADD 10001011000 -> 0010; SUB 11001011000 -> 1010; AND 10001010000 -> 0110; ORR 10101010000 -> 0100; EOR 11001010000 -> 1001; STUR 11111000000 and LDUR 11111000010 -> 0010; CBZ, opcode[10:3]=10110100 with any low 3 bits -> 0111; MOVZ, opcode[10:2]=110100101 -> 1101.
REQ-017 Any other opcode SHALL be illegal: respIllegal=1, respResult=0, respOverflow=0, respZero=0, and the ALU is not issued.
REQ-018 aluControl, data1 and data2 SHALL be held stable throughout ISSUE; outside ISSUE, aluControl SHALL be 0000.
REQ-019 At the end of ISSUE, the block SHALL capture respResult=aluResult (0 for CBZ), respOverflow=overflow for ADD/SUB and 0 for all other operations, and respZero=zeroFlag for CBZ and (aluResult==0) for all other operations, then go to RESP.
REQ-020 Latency: respValid SHALL rise 2 edges after the accept edge for legal opcodes and 1 edge after it for illegal opcodes.
REQ-021 In RESP, respValid SHALL be 1 and all resp* outputs SHALL be held until an edge with respReady=1, after which the FSM goes to IDLE.
REQ-022 A new request SHALL NOT be accepted in the same cycle as response completion; throughput is at most one operation per 3 cycles.
REQ-023 reqValid asserted outside IDLE SHALL be ignored and SHALL NOT be lost: the requester holds it until reqReady=1.
REQ-024 respReady asserted outside RESP SHALL have no effect.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately force state IDLE, reqReady=1 once released, respValid=0, aluControl=0000, data1=0, data2=0, and respResult, respOverflow, respZero and respIllegal to 0.
REQ-026 Reset mid-operation (in ISSUE or RESP) SHALL discard the operation with no response produced.

Configuration
REQ-027 Macro ALU_SEQ_OPCNT_EN SHALL control the operation counter.
REQ-028 With ALU_SEQ_OPCNT_EN defined, the block SHALL provide output opCount of width CNT_W that increments on each response handshake with respIllegal=0, wraps from all-ones to 0, and is reset to 0.
REQ-029 Without ALU_SEQ_OPCNT_EN, the opCount port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-030 Test: ADD with data1=0xFFFFFFFF, data2=1 and respReady=1 -> aluControl=0010 during ISSUE; response 2 edges after accept with respResult=0, respOverflow=1, respZero=1.
REQ-031 Test: CBZ with opcode 10110100101 and data2=0 -> aluControl=0111; respZero=1, respResult=0.
REQ-032 Test: opcode 00000000000 -> no ISSUE cycle; respValid after 1 edge with respIllegal=1; opCount unchanged.
REQ-033 Test: SUB 5-3 with respReady held 0 for 4 cycles -> respResult=2 stable and reqReady=0 throughout; IDLE after respReady=1.
REQ-034 Test: rst_n pulsed low during ISSUE -> respValid stays 0 and all outputs return to reset values asynchronously.
REQ-035 Test: with ALU_SEQ_OPCNT_EN and CNT_W=4, run 17 legal operations -> opCount=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequences one LEGv8 ALU operation per request: decode, issue to an external ALU, hold response.
// Optional ALU_SEQ_OPCNT_EN adds opCount, a wrapping count of completed legal operations.
module alu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [10:0]       reqOpcode,
  input  logic [31:0]       reqData1,
  input  logic [31:0]       reqData2,
  output logic [3:0]        aluControl,
  output logic [31:0]       data1,
  output logic [31:0]       data2,
  input  logic [31:0]       aluResult,
  input  logic              overflow,
  input  logic              zeroFlag,
  output logic              respValid,
  input  logic              respReady,
  output logic [31:0]       respResult,
  output logic              respOverflow,
  output logic              respZero,
  output logic              respIllegal
`ifdef ALU_SEQ_OPCNT_EN
  ,
  output logic [CNT_W-1:0]  opCount
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state;
  logic       is_addsub, is_cbz;
  logic       dec_legal, dec_addsub, dec_cbz;
  logic [3:0] dec_ctrl;

  always_comb begin
    dec_legal  = 1'b1;
    dec_addsub = 1'b0;
    dec_cbz    = 1'b0;
    dec_ctrl   = 4'b0000;
    casez (reqOpcode)
      11'b10001011000: begin dec_ctrl = 4'b0010; dec_addsub = 1'b1; end
      11'b11001011000: begin dec_ctrl = 4'b1010; dec_addsub = 1'b1; end
      11'b10001010000: dec_ctrl = 4'b0110;
      11'b10101010000: dec_ctrl = 4'b0100;
      11'b11001010000: dec_ctrl = 4'b1001;
      11'b11111000000,
      11'b11111000010: dec_ctrl = 4'b0010;
      11'b10110100???: begin dec_ctrl = 4'b0111; dec_cbz = 1'b1; end
      11'b110100101??: dec_ctrl = 4'b1101;
      default:         dec_legal = 1'b0;
    endcase
  end

  assign reqReady  = (state == IDLE);
  assign respValid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      aluControl   <= 4'b0000;
      data1        <= '0;
      data2        <= '0;
      respResult   <= '0;
      respOverflow <= 1'b0;
      respZero     <= 1'b0;
      respIllegal  <= 1'b0;
      is_addsub    <= 1'b0;
      is_cbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          data1     <= reqData1;
          data2     <= reqData2;
          is_addsub <= dec_addsub;
          is_cbz    <= dec_cbz;
          if (dec_legal) begin
            aluControl  <= dec_ctrl;
            respIllegal <= 1'b0;
            state       <= ISSUE;
          end else begin
            // illegal opcodes skip the ALU and answer directly
            aluControl   <= 4'b0000;
            respIllegal  <= 1'b1;
            respResult   <= '0;
            respOverflow <= 1'b0;
            respZero     <= 1'b0;
            state        <= RESP;
          end
        end
        ISSUE: begin
          respResult   <= is_cbz ? 32'd0 : aluResult;
          respOverflow <= is_addsub & overflow;
          respZero     <= is_cbz ? zeroFlag : (aluResult == 32'd0);
          aluControl   <= 4'b0000;
          state        <= RESP;
        end
        RESP: if (respReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_OPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      opCount <= '0;
    else if (state == RESP && respReady && !respIllegal)
      opCount <= opCount + 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a response scoreboard.
module tb_alu_sequencer;
  localparam int CW = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        reqValid = 1'b0, reqReady;
  logic [10:0] reqOpcode = '0;
  logic [31:0] reqData1 = '0, reqData2 = '0;
  logic [3:0]  aluControl;
  logic [31:0] data1, data2, aluResult;
  logic        overflow, zeroFlag;
  logic        respValid, respReady = 1'b0;
  logic [31:0] respResult;
  logic        respOverflow, respZero, respIllegal;
`ifdef ALU_SEQ_OPCNT_EN
  logic [CW-1:0] opCount;
`endif

  alu_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
    .reqOpcode(reqOpcode), .reqData1(reqData1), .reqData2(reqData2),
    .aluControl(aluControl), .data1(data1), .data2(data2),
    .aluResult(aluResult), .overflow(overflow), .zeroFlag(zeroFlag),
    .respValid(respValid), .respReady(respReady), .respResult(respResult),
    .respOverflow(respOverflow), .respZero(respZero), .respIllegal(respIllegal)
`ifdef ALU_SEQ_OPCNT_EN
    , .opCount(opCount)
`endif
  );

  always #5 clk = ~clk;

  // external ALU; overflow is the unsigned carry/borrow out
  logic [32:0] wide;
  always_comb begin
    wide = '0;
    case (aluControl)
      4'b0010: wide = {1'b0, data1} + {1'b0, data2};
      4'b1010: wide = {1'b0, data1} - {1'b0, data2};
      4'b0110: wide = {1'b0, data1 & data2};
      4'b0100: wide = {1'b0, data1 | data2};
      4'b1001: wide = {1'b0, data1 ^ data2};
      4'b0111: wide = {1'b0, data2};
      4'b1101: wide = {1'b0, data2};
      default: wide = '0;
    endcase
    aluResult = wide[31:0];
    overflow  = wide[32];
    zeroFlag  = (wide[31:0] == 32'd0);
  end

  typedef struct packed {
    logic        legal;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0, exp_cnt = 0;

  function automatic exp_t model(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    m = '0;
    m.legal = 1'b1;
    casez (op)
      11'b10001011000: begin m.ctrl = 4'b0010; m.res = a + b; m.ovf = (a > ~b); end
      11'b11001011000: begin m.ctrl = 4'b1010; m.res = a - b; m.ovf = (a < b); end
      11'b10001010000: begin m.ctrl = 4'b0110; m.res = a & b; end
      11'b10101010000: begin m.ctrl = 4'b0100; m.res = a | b; end
      11'b11001010000: begin m.ctrl = 4'b1001; m.res = a ^ b; end
      11'b11111000000,
      11'b11111000010: begin m.ctrl = 4'b0010; m.res = a + b; end
      11'b10110100???: begin m.ctrl = 4'b0111; m.res = 32'd0; end
      11'b110100101??: begin m.ctrl = 4'b1101; m.res = b; end
      default: m.legal = 1'b0;
    endcase
    if (m.legal) m.zero = (m.ctrl == 4'b0111) ? (b == 32'd0) : (m.res == 32'd0);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit early);
    exp_t e, p;
    e = model(op, a, b);
    q.push_back(e);
    reqValid = 1'b1; reqOpcode = op; reqData1 = a; reqData2 = b; respReady = early;
    tick();
    reqValid = 1'b0;
    chk("ready_low", 32'(reqReady), 32'd0);
    if (e.legal) begin
      chk("issue_ctrl", 32'(aluControl), 32'(e.ctrl));
      chk("issue_d1", data1, a);
      chk("issue_d2", data2, b);
      chk("issue_vld", 32'(respValid), 32'd0);
      tick();
    end
    chk("resp_vld", 32'(respValid), 32'd1);
    chk("resp_ctrl0", 32'(aluControl), 32'd0);
    for (int i = 0; i < hold; i++) begin
      respReady = 1'b0;
      tick();
      chk("hold_vld", 32'(respValid), 32'd1);
      chk("hold_rdy", 32'(reqReady), 32'd0);
      chk("hold_res", respResult, e.res);
    end
    if (q.size() == 0) begin
      checks++; errors++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      p = q.pop_front();
      chk("res", respResult, p.res);
      chk("ovf", 32'(respOverflow), 32'(p.ovf));
      chk("zero", 32'(respZero), 32'(p.zero));
      chk("illegal", 32'(respIllegal), 32'(!p.legal));
    end
    respReady = 1'b1;
    tick();
    respReady = 1'b0;
    if (e.legal) exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("done_rdy", 32'(reqReady), 32'd1);
    chk("done_vld", 32'(respValid), 32'd0);
`ifdef ALU_SEQ_OPCNT_EN
    chk("opcnt", 32'(opCount), 32'(exp_cnt));
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, 32'(reqReady), 32'd1);
    chk({tag, "_vld"}, 32'(respValid), 32'd0);
    chk({tag, "_ctrl"}, 32'(aluControl), 32'd0);
    chk({tag, "_d1"}, data1, 32'd0);
    chk({tag, "_d2"}, data2, 32'd0);
    chk({tag, "_res"}, respResult, 32'd0);
    chk({tag, "_flags"}, 32'({respOverflow, respZero, respIllegal}), 32'd0);
`ifdef ALU_SEQ_OPCNT_EN
    chk({tag, "_opcnt"}, 32'(opCount), 32'd0);
`endif
  endtask

  initial begin
    #12;
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    do_op(11'b10001011000, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);      // ADD carry-out, zero
    do_op(11'b10110100101, 32'd7, 32'd0, 0, 1'b0);              // CBZ taken
    do_op(11'b00000000000, 32'd1, 32'd2, 1, 1'b0);              // illegal
    do_op(11'b11001011000, 32'd5, 32'd3, 4, 1'b0);              // SUB with backpressure
    do_op(11'b10001010000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
    do_op(11'b10101010000, 32'h1200_0000, 32'h0000_0034, 0, 1'b0);
    do_op(11'b11001010000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b0);
    do_op(11'b11111000010, 32'h0000_1000, 32'h0000_0010, 0, 1'b0);
    do_op(11'b11111000000, 32'hFFFF_FFF0, 32'h0000_0020, 0, 1'b0); // STUR ignores carry
    do_op(11'b11010010110, 32'h1111_1111, 32'h0000_ABCD, 0, 1'b0);
    do_op(11'b10110100000, 32'd0, 32'd5, 0, 1'b0);              // CBZ not taken
    do_op(11'b11001011000, 32'd3, 32'd5, 0, 1'b0);              // SUB borrow
    do_op(11'b11111111111, 32'd9, 32'd9, 0, 1'b0);              // illegal

    // reset pulse while in ISSUE discards the operation
    reqValid = 1'b1; reqOpcode = 11'b10001011000; reqData1 = 32'd10; reqData2 = 32'd20;
    tick();
    reqValid = 1'b0;
    chk("mid_ctrl", 32'(aluControl), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid");
    #2 rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_novld", 32'(respValid), 32'd0);
    end

    for (int i = 0; i < 17; i++)
      do_op(11'b10001011000, $urandom, $urandom_range(0, 1000), 0, i[0]);
`ifdef ALU_SEQ_OPCNT_EN
    chk("opcnt_wrap", 32'(opCount), 32'd1);
`endif
    do_op(11'b01010101010, 32'd1, 32'd1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
